// File: rtl/div_pkg.sv
// Shared constants and state encoding for the signed sequential divider.
package div_pkg;

   localparam int DIV_WIDTH  = 32;
   localparam int ITER_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/adder_32_bit.sv
// Ripple-style binary adder with carry-in; the divider widens it by one bit
// so the partial remainder keeps its sign.
module adder_32_bit #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum
);

   assign o_sum = i_a + i_b + {{(W-1){1'b0}}, i_cin};

endmodule

// File: rtl/div_32_bit.sv
// Signed non-restoring divider: one quotient bit per clock on operand
// magnitudes, followed by a restore/sign fix-up cycle.
module div_32_bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   div_state_e              r_state;
   div_state_e              w_next;
   logic [ITER_CNT_W-1:0]   r_cnt;
   logic [WIDTH:0]          r_a;
   logic [WIDTH-1:0]        r_q;
   logic [WIDTH-1:0]        r_m;
   logic                    r_q_neg;
   logic                    r_r_neg;
   logic [WIDTH-1:0]        r_quotient;
   logic [WIDTH-1:0]        r_remainder;
   logic                    r_dbz;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_div_zero;
   logic                    w_last_iter;
   logic                    w_sub;
   logic [WIDTH:0]          w_add_a;
   logic [WIDTH:0]          w_add_b;
   logic [WIDTH:0]          w_sum;
   logic [WIDTH-1:0]        w_rem_mag;
   logic [WIDTH-1:0]        w_quot_fix;
   logic [WIDTH-1:0]        w_rem_fix;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      magnitude = v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      apply_sign = neg ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   assign w_div_zero  = (divisor == {WIDTH{1'b0}});
   assign w_last_iter = (r_cnt == ITER_CNT_W'(WIDTH - 1));

   // Adder operand selection: shifted iteration in RUN, restore add in FIX
   always_comb begin
      w_add_a = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
      w_sub   = ~r_a[WIDTH];
      if (r_state == FIX) begin
         w_add_a = r_a;
         w_sub   = 1'b0;
      end else begin
         w_add_a = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
      end
      w_add_b = w_sub ? ~{1'b0, r_m} : {1'b0, r_m};
   end

   adder_32_bit #(
      .W (WIDTH + 1)
   ) u_adder (
      .i_a   (w_add_a),
      .i_b   (w_add_b),
      .i_cin (w_sub),
      .o_sum (w_sum)
   );

   // Restore a negative final remainder, then give both results their signs
   always_comb begin
      w_rem_mag  = r_a[WIDTH-1:0];
      if (r_a[WIDTH]) begin
         w_rem_mag = w_sum[WIDTH-1:0];
      end else begin
         w_rem_mag = r_a[WIDTH-1:0];
      end
      w_quot_fix = apply_sign(r_q, r_q_neg);
      w_rem_fix  = apply_sign(w_rem_mag, r_r_neg);
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = w_div_zero ? DONE : RUN;
            end else begin
               w_next = IDLE;
            end
         end
         RUN: begin
            if (w_last_iter) begin
               w_next = FIX;
            end else begin
               w_next = RUN;
            end
         end
         FIX:     w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register with status flags tracking the next state
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != IDLE);
         r_done  <= (w_next == DONE);
      end
   end

   // Datapath: operand capture, iterations and result registers
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_cnt       <= {ITER_CNT_W{1'b0}};
         r_a         <= {(WIDTH+1){1'b0}};
         r_q         <= {WIDTH{1'b0}};
         r_m         <= {WIDTH{1'b0}};
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_quotient  <= {WIDTH{1'b0}};
         r_remainder <= {WIDTH{1'b0}};
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && w_div_zero) begin
                  r_quotient  <= {WIDTH{1'b1}};
                  r_remainder <= dividend;
                  r_dbz       <= 1'b1;
               end else if (start) begin
                  r_cnt   <= {ITER_CNT_W{1'b0}};
                  r_a     <= {(WIDTH+1){1'b0}};
                  r_q     <= magnitude(dividend);
                  r_m     <= magnitude(divisor);
                  r_q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_r_neg <= dividend[WIDTH-1];
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            RUN: begin
               r_a   <= w_sum;
               r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
               r_cnt <= r_cnt + {{(ITER_CNT_W-1){1'b0}}, 1'b1};
            end
            FIX: begin
               r_quotient  <= w_quot_fix;
               r_remainder <= w_rem_fix;
               r_dbz       <= 1'b0;
            end
            DONE: begin
               r_cnt <= r_cnt;
            end
            default: begin
               r_cnt <= {ITER_CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_32_bit.sv
// Directed self-checking bench for div_32_bit.
module tb_div_32_bit;

   logic        clk;
   logic        clear_n;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int tests_run    = 0;
   int tests_failed = 0;

   div_32_bit #(.WIDTH(32)) dut (
      .clk         (clk),
      .clear_n     (clear_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called 1 time unit after a rising edge; returns edges counted from the
   // start-sampling edge up to the edge after which done is seen high.
   task automatic run_div(input logic [31:0] dd, input logic [31:0] dv,
                          output int lat);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      lat      = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         lat++;
         start = 1'b0;
         if (done) break;
      end
   endtask

   task automatic test_reset();
      clear_n = 1'b0;
      start = 1'b0; dividend = 32'd0; divisor = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
         tests_failed++;
         $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h, need all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      clear_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      run_div(32'd100, 32'd7, lat);
      tests_run++;
      if (lat !== 34 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_100_7: got lat=%0d q=%h r=%h dbz=%b, need 34 0000000e 00000002 0",
                  lat, quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL done_one_cycle: got done=%b busy=%b, need 0 0", done, busy);
      end
   endtask

   task automatic test_signs();
      logic [31:0] dd [3] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FFF9};
      logic [31:0] dv [3] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFE};
      logic [31:0] eq [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd3};
      logic [31:0] er [3] = '{32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_div(dd[i], dv[i], lat);
         tests_run++;
         if (lat !== 34 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL signed_%0d: got lat=%0d q=%h r=%h dbz=%b, need 34 %h %h 0",
                     i, lat, quotient, remainder, div_by_zero, eq[i], er[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_overflow_zero();
      int lat;
      run_div(32'h8000_0000, 32'hFFFF_FFFF, lat);
      tests_run++;
      if (lat !== 34 || quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow: got lat=%0d q=%h r=%h dbz=%b, need 34 80000000 00000000 0",
                  lat, quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
      run_div(32'd0, 32'd5, lat);
      tests_run++;
      if (lat !== 34 || quotient !== 32'd0 || remainder !== 32'd0) begin
         tests_failed++;
         $display("FAIL zero_dividend: got lat=%0d q=%h r=%h, need 34 0 0", lat, quotient, remainder);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_div_by_zero();
      int lat;
      run_div(32'd5, 32'd0, lat);
      tests_run++;
      if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL div_by_zero: got lat=%0d q=%h r=%h dbz=%b, need 1 ffffffff 00000005 1",
                  lat, quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      int lat;
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      tests_run++;
      if (busy !== 1'b1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_during_run: got busy=%b q=%h r=%h dbz=%b, need 1 ffffffff 00000005 1",
                  busy, quotient, remainder, div_by_zero);
      end
      start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 11;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk); #1;
         lat++;
      end
      tests_run++;
      if (lat !== 34 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_ignored: got lat=%0d q=%h r=%h dbz=%b, need 34 0000000e 00000002 0",
                  lat, quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      // done is high now: a start here must be ignored
      start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_in_done_cycle: got busy=%b done=%b, need 0 0", busy, done);
      end
      run_div(32'd20, 32'd6, lat);
      tests_run++;
      if (lat !== 34 || quotient !== 32'd3 || remainder !== 32'd2) begin
         tests_failed++;
         $display("FAIL back_to_back: got lat=%0d q=%h r=%h, need 34 00000003 00000002",
                  lat, quotient, remainder);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      int lat;
      int seen_done = 0;
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      clear_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
         tests_failed++;
         $display("FAIL async_reset: got busy=%b done=%b dbz=%b q=%h r=%h, need all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      repeat (3) begin @(posedge clk); #1; end
      clear_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen_done = 1;
      end
      tests_run++;
      if (seen_done !== 0) begin
         tests_failed++;
         $display("FAIL no_done_after_reset: got activity=%0d, need 0", seen_done);
      end
      run_div(32'd9, 32'd3, lat);
      tests_run++;
      if (lat !== 34 || quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL after_reset_9_3: got lat=%0d q=%h r=%h dbz=%b, need 34 3 0 0",
                  lat, quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_overflow_zero();
      test_div_by_zero();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
